hawk_page_rd_req: RTL and testbench

Page-read request generator that sits directly upstream of `hawk_axird_master`, on its AXI slave read-address side. It takes one page-aligned read command from the HACD control logic and splits it into fixed-length INCR bursts. It drives those bursts on AR, then watches the R handshakes leaving the read bridge to count beats, check `rlast`/`rresp`, and report page completion. The bridge's FIFO_DELAY logic throttles `arready`; this block relies on it for buffer-space flow control.

---
 rtl/hawk_rd_pkg.sv | 27 ++
 rtl/hawk_page_rd_req.sv | 173 +++++++++++++++++
 tb/tb_hawk_page_rd_req.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hawk_rd_pkg.sv
// Shared types, AXI constants and geometry helpers for the HAWK page-read path.
package hawk_rd_pkg;

    localparam int HACD_AXI4_ADDR_WIDTH = 32;
    localparam int HACD_AXI4_DATA_WIDTH = 512;
    localparam int HACD_AXI4_ID_WIDTH   = 4;
    localparam int HACD_AXI4_USER_WIDTH = 1;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} rd_state_t;

    function automatic int calc_beats_per_page(input int page_bytes, input int data_width);
        return page_bytes / (data_width / 8);
    endfunction

    function automatic int calc_num_bursts(input int page_bytes, input int data_width,
                                           input int burst_beats);
        return calc_beats_per_page(page_bytes, data_width) / burst_beats;
    endfunction

    function automatic int calc_burst_bytes(input int data_width, input int burst_beats);
        return burst_beats * (data_width / 8);
    endfunction

endpackage

// File: rtl/hawk_page_rd_req.sv
// Splits one page-aligned read command into fixed INCR bursts on AR and tracks
// the returning R beats to report page completion and sticky errors.
module hawk_page_rd_req
    import hawk_rd_pkg::*;
#(
    parameter int ADDR_WIDTH  = HACD_AXI4_ADDR_WIDTH,
    parameter int DATA_WIDTH  = HACD_AXI4_DATA_WIDTH,
    parameter int ID_WIDTH    = HACD_AXI4_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] RD_ID = '0,
    parameter int PAGE_BYTES  = 4096,
    parameter int BURST_BEATS = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    output logic                            busy,
    output logic                            done_valid,
    output logic                            done_err,
    output logic [ID_WIDTH-1:0]             m_axi_arid,
    output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic                            m_axi_arlock,
    output logic [3:0]                      m_axi_arcache,
    output logic [2:0]                      m_axi_arprot,
    output logic [3:0]                      m_axi_arqos,
    output logic [3:0]                      m_axi_arregion,
    output logic [HACD_AXI4_USER_WIDTH-1:0] m_axi_aruser,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic                            mon_rvalid,
    input  logic                            mon_rready,
    input  logic                            mon_rlast,
    input  logic [ID_WIDTH-1:0]             mon_rid,
    input  logic [1:0]                      mon_rresp
);

    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int BEATS_PER_PAGE = calc_beats_per_page(PAGE_BYTES, DATA_WIDTH);
    localparam int NUM_BURSTS     = calc_num_bursts(PAGE_BYTES, DATA_WIDTH, BURST_BEATS);
    localparam int BURST_BYTES    = calc_burst_bytes(DATA_WIDTH, BURST_BEATS);
    localparam int CNT_W          = $clog2(BEATS_PER_PAGE) + 1;
    localparam int BIDX_W         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int BURST_SHIFT    = $clog2(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ~ADDR_WIDTH'(PAGE_BYTES - 1);

    if (PAGE_BYTES <= 0 || (PAGE_BYTES & (PAGE_BYTES - 1)) != 0) begin : g_chk_page
        $error("PAGE_BYTES must be a power of 2");
    end
    if (BURST_BEATS <= 0 || BURST_BEATS > 256 || (BURST_BEATS & (BURST_BEATS - 1)) != 0) begin : g_chk_burst
        $error("BURST_BEATS must be a power of 2 no larger than 256");
    end
    if (DATA_WIDTH % 8 != 0 || (BYTES_PER_BEAT & (BYTES_PER_BEAT - 1)) != 0) begin : g_chk_data
        $error("DATA_WIDTH must be a power-of-2 number of bytes");
    end
    if (PAGE_BYTES % BURST_BYTES != 0) begin : g_chk_div
        $error("PAGE_BYTES must be a multiple of BURST_BEATS*BYTES_PER_BEAT");
    end

    rd_state_t               state, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [BIDX_W-1:0]       burst_idx_q, burst_idx_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    err_q, err_d;

    logic                    req_ready_d, busy_d, done_valid_d, done_err_d, arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_d;

    logic                    beat_hs, count_en, slot_last, beat_err, last_burst;

    assign beat_hs    = mon_rvalid & mon_rready & (mon_rid == RD_ID);
    assign count_en   = (state == ISSUE || state == WAIT_R) && beat_hs &&
                        (beat_cnt_q < CNT_W'(BEATS_PER_PAGE));
    assign slot_last  = (beat_cnt_q % CNT_W'(BURST_BEATS)) == CNT_W'(BURST_BEATS - 1);
    assign beat_err   = (mon_rresp != AXI_RESP_OKAY) | (mon_rlast != slot_last);
    assign last_burst = burst_idx_q == BIDX_W'(NUM_BURSTS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_q         <= '0;
            burst_idx_q    <= '0;
            beat_cnt_q     <= '0;
            err_q          <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b0;
            done_valid     <= 1'b0;
            done_err       <= 1'b0;
            m_axi_arvalid  <= 1'b0;
            m_axi_araddr   <= '0;
            m_axi_arid     <= '0;
            m_axi_arlen    <= '0;
            m_axi_arsize   <= '0;
            m_axi_arburst  <= '0;
        end else begin
            state          <= state_d;
            base_q         <= base_d;
            burst_idx_q    <= burst_idx_d;
            beat_cnt_q     <= beat_cnt_d;
            err_q          <= err_d;
            req_ready      <= req_ready_d;
            busy           <= busy_d;
            done_valid     <= done_valid_d;
            done_err       <= done_err_d;
            m_axi_arvalid  <= arvalid_d;
            m_axi_araddr   <= araddr_d;
            m_axi_arid     <= RD_ID;
            m_axi_arlen    <= 8'(BURST_BEATS - 1);
            m_axi_arsize   <= 3'($clog2(BYTES_PER_BEAT));
            m_axi_arburst  <= AXI_BURST_INCR;
        end
    end

    always_comb begin
        state_d     = state;
        base_d      = base_q;
        burst_idx_d = burst_idx_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    base_d      = req_addr & PAGE_MASK;
                    err_d       = |(req_addr & ~PAGE_MASK);
                    burst_idx_d = '0;
                    beat_cnt_d  = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE, WAIT_R: begin
                if (count_en) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_err) err_d = 1'b1;
                end
                // Last beat coinciding with the last AR handshake skips WAIT_R.
                if (state == ISSUE) begin
                    if (m_axi_arready) begin
                        burst_idx_d = burst_idx_q + 1'b1;
                        if (last_burst)
                            state_d = (beat_cnt_d == CNT_W'(BEATS_PER_PAGE)) ? DONE : WAIT_R;
                    end
                end else if (beat_cnt_d == CNT_W'(BEATS_PER_PAGE)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so every port comes from a flop.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        done_valid_d = (state_d == DONE);
        done_err_d   = (state_d == DONE) & err_d;
        arvalid_d    = (state_d == ISSUE);
        araddr_d     = m_axi_araddr;
        if (state_d == ISSUE)
            araddr_d = base_d + (ADDR_WIDTH'(burst_idx_d) << BURST_SHIFT);
    end

    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = '0;
    assign m_axi_arprot   = '0;
    assign m_axi_arqos    = '0;
    assign m_axi_arregion = '0;
    assign m_axi_aruser   = '0;

endmodule

// File: tb/tb_hawk_page_rd_req.sv
// Directed bench for hawk_page_rd_req at default geometry (64 B beats, 4 x 16-beat bursts).
module tb_hawk_page_rd_req;
    import hawk_rd_pkg::*;

    localparam int AW = HACD_AXI4_ADDR_WIDTH;
    localparam int IW = HACD_AXI4_ID_WIDTH;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic                            req_valid, req_ready, busy, done_valid, done_err;
    logic [AW-1:0]                   req_addr;
    logic [IW-1:0]                   m_axi_arid;
    logic [AW-1:0]                   m_axi_araddr;
    logic [7:0]                      m_axi_arlen;
    logic [2:0]                      m_axi_arsize;
    logic [1:0]                      m_axi_arburst;
    logic                            m_axi_arlock;
    logic [3:0]                      m_axi_arcache;
    logic [2:0]                      m_axi_arprot;
    logic [3:0]                      m_axi_arqos;
    logic [3:0]                      m_axi_arregion;
    logic [HACD_AXI4_USER_WIDTH-1:0] m_axi_aruser;
    logic                            m_axi_arvalid, m_axi_arready;
    logic                            mon_rvalid, mon_rready, mon_rlast;
    logic [IW-1:0]                   mon_rid;
    logic [1:0]                      mon_rresp;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hawk_page_rd_req dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .busy(busy), .done_valid(done_valid), .done_err(done_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
        .mon_rid(mon_rid), .mon_rresp(mon_rresp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [AW-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        check("req_ready_before_accept", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic run_ars(input logic [AW-1:0] base, input int stall);
        int            w;
        logic          stable;
        logic [AW-1:0] a0;
        for (int k = 0; k < 4; k++) begin
            m_axi_arready = (stall == 0);
            w = 0;
            while (!m_axi_arvalid && w < 50) begin
                step();
                w++;
            end
            check("arvalid_no_bubble", 64'(w), 64'd0);
            a0 = m_axi_araddr;
            check("araddr", 64'(a0), 64'(base + AW'(k) * 32'h400));
            if (k == 0) begin
                check("arlen", 64'(m_axi_arlen), 64'd15);
                check("arsize", 64'(m_axi_arsize), 64'd6);
                check("arburst", 64'(m_axi_arburst), 64'd1);
                check("arid", 64'(m_axi_arid), 64'd0);
            end
            if (stall > 0) begin
                stable = 1'b1;
                for (int s = 0; s < stall; s++) begin
                    step();
                    if (!m_axi_arvalid || m_axi_araddr !== a0) stable = 1'b0;
                end
                check("ar_stable_while_stalled", 64'(stable), 64'd1);
            end
            m_axi_arready = 1'b1;
            step();
        end
        m_axi_arready = 1'b0;
        check("arvalid_after_last_ar", 64'(m_axi_arvalid), 64'd0);
    endtask

    task automatic send_beats(input int bad_resp, input int early_last, input logic exp_err,
                              input bit foreign);
        mon_rready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (foreign && i == 30) begin
                mon_rvalid = 1'b1; mon_rid = 4'd5; mon_rresp = 2'b10; mon_rlast = 1'b1;
                step();
            end
            mon_rvalid = 1'b1;
            mon_rid    = '0;
            mon_rresp  = (i == bad_resp) ? 2'b10 : 2'b00;
            mon_rlast  = ((i % 16) == 15) || (i == early_last);
            if (i == 63) check("no_done_before_last_beat", 64'(done_valid), 64'd0);
            step();
        end
        mon_rvalid = 1'b0; mon_rlast = 1'b0; mon_rresp = 2'b00;
        check("done_valid", 64'(done_valid), 64'd1);
        check("done_err", 64'(done_err), 64'(exp_err));
        step();
        check("done_one_cycle", 64'(done_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; m_axi_arready = 1'b0;
        mon_rvalid = 1'b0; mon_rready = 1'b0; mon_rlast = 1'b0; mon_rid = '0; mon_rresp = '0;

        repeat (3) step();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_arlen", 64'(m_axi_arlen), 64'd0);
        rst_n = 1'b1;
        step();
        check("req_ready_after_rst", 64'(req_ready), 64'd1);

        // Nominal page, back-to-back ARs, one foreign-ID beat mixed in
        do_req(32'h8000_1000);
        run_ars(32'h8000_1000, 0);
        send_beats(-1, -1, 1'b0, 1'b1);

        // arready stalled 10 cycles per AR
        do_req(32'h8000_1000);
        run_ars(32'h8000_1000, 10);
        send_beats(-1, -1, 1'b0, 1'b0);

        // SLVERR on beat 20
        do_req(32'h8000_1000);
        run_ars(32'h8000_1000, 0);
        send_beats(20, -1, 1'b1, 1'b0);

        // Early rlast on beat 7
        do_req(32'h8000_1000);
        run_ars(32'h8000_1000, 0);
        send_beats(-1, 7, 1'b1, 1'b0);

        // Misaligned request
        do_req(32'h8000_1040);
        run_ars(32'h8000_1000, 0);
        send_beats(-1, -1, 1'b1, 1'b0);

        // Reset during the second AR
        do_req(32'h8000_2000);
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        check("second_ar_addr", 64'(m_axi_araddr), 64'h8000_2400);
        check("second_ar_valid", 64'(m_axi_arvalid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_araddr", 64'(m_axi_araddr), 64'd0);
        check("midrst_arlen", 64'(m_axi_arlen), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("req_ready_after_midrst", 64'(req_ready), 64'd1);

        // Erroneous beats in IDLE must not taint the next page
        mon_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mon_rvalid = 1'b1; mon_rid = '0; mon_rresp = 2'b11; mon_rlast = 1'b1;
            step();
        end
        mon_rvalid = 1'b0; mon_rlast = 1'b0; mon_rresp = 2'b00;
        check("idle_beats_no_busy", 64'(busy), 64'd0);
        do_req(32'h8000_3000);
        run_ars(32'h8000_3000, 0);
        send_beats(-1, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
